// File: rtl/row_uram_arbiter_pkg.sv
// Shared types and defaults for the row-level URAM arbiter.
package row_uram_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANTED,
        ARB_LOCKED,
        ARB_RELEASE
    } arb_state_t;

    localparam int ROW_NUM_CORES = 8;
    localparam int ROW_ADDR_W    = 12;
    localparam int ROW_DATA_W    = 32;

endpackage

// File: rtl/row_uram_arbiter_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_priority_picker
    import row_uram_arbiter_pkg::*;
#(
    parameter int NUM_CORES = ROW_NUM_CORES,
    parameter int IDX_W     = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_CORES-1:0] winner,
    output logic [IDX_W-1:0]     idx,
    output logic                 valid
);

    localparam int W2 = 2 * NUM_CORES;

    logic [W2-1:0] dbl;
    logic [W2-1:0] dbl_win;

    // Subtracting the pointer bit clears the lowest request at/above ptr;
    // the upper copy supplies the wrap-around candidate.
    assign dbl     = {req, req};
    assign dbl_win = dbl & ~(dbl - (W2'(1) << ptr));
    assign winner  = dbl_win[NUM_CORES-1:0] | dbl_win[W2-1:NUM_CORES];
    assign valid   = |req;

    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (winner[i]) idx = idx | IDX_W'(i);
        end
    end

endmodule

// File: rtl/row_uram_arbiter.sv
// Row arbiter: hands one shared URAM port to one core at a time, with lock
// hold, a grant-free bubble between owners and a registered URAM stage.
module row_uram_arbiter
    import row_uram_arbiter_pkg::*;
#(
    parameter int NUM_CORES = ROW_NUM_CORES,
    parameter int ADDR_W    = ROW_ADDR_W,
    parameter int DATA_W    = ROW_DATA_W,
    parameter int IDX_W     = $clog2(NUM_CORES)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CORES-1:0]          i_core_req,
    input  logic [NUM_CORES-1:0]          i_core_locked,
    input  logic [NUM_CORES-1:0]          i_core_uram_en,
    input  logic [NUM_CORES*ADDR_W-1:0]   i_core_uram_addr,
    input  logic [NUM_CORES*DATA_W-1:0]   i_core_uram_wdat,
    input  logic [NUM_CORES-1:0]          i_core_uram_we,
    input  logic                          i_uram_emptied,
    output logic [NUM_CORES-1:0]          o_core_grant,
    output logic [NUM_CORES-1:0]          o_uram_emptied,
    output logic                          o_uram_en,
    output logic [ADDR_W-1:0]             o_uram_addr,
    output logic [DATA_W-1:0]             o_uram_wr_data,
    output logic                          o_uram_wr_en,
    output logic                          o_busy,
    output logic [IDX_W-1:0]              o_owner_idx
);

    arb_state_t              state;
    logic [IDX_W-1:0]        owner;
    logic [IDX_W-1:0]        rr_ptr;
    logic [NUM_CORES-1:0]    pick_oh;
    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_vld;
    logic                    own_req;
    logic                    own_locked;
    logic                    hold;

    rr_priority_picker #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req    (i_core_req),
        .ptr    (rr_ptr),
        .winner (pick_oh),
        .idx    (pick_idx),
        .valid  (pick_vld)
    );

    assign own_req    = i_core_req[owner];
    assign own_locked = i_core_locked[owner];

    // Owner keeps the grant into the next cycle, so its URAM inputs pass.
    assign hold = ((state == ARB_GRANTED) && (own_locked || own_req)) ||
                  ((state == ARB_LOCKED)  && own_locked);

    assign o_busy      = (state != ARB_IDLE);
    assign o_owner_idx = owner;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ARB_IDLE;
            owner          <= '0;
            rr_ptr         <= '0;
            o_core_grant   <= '0;
            o_uram_emptied <= '0;
            o_uram_en      <= 1'b0;
            o_uram_addr    <= '0;
            o_uram_wr_data <= '0;
            o_uram_wr_en   <= 1'b0;
        end else begin
            o_uram_emptied <= {NUM_CORES{i_uram_emptied}};

            case (state)
                ARB_IDLE: begin
                    if (pick_vld) begin
                        state        <= ARB_GRANTED;
                        owner        <= pick_idx;
                        o_core_grant <= pick_oh;
                    end
                end
                ARB_GRANTED: begin
                    if (own_locked) begin
                        state <= ARB_LOCKED;
                    end else if (!own_req) begin
                        state        <= ARB_RELEASE;
                        o_core_grant <= '0;
                    end
                end
                ARB_LOCKED: begin
                    if (!own_locked) begin
                        state        <= ARB_RELEASE;
                        o_core_grant <= '0;
                    end
                end
                default: begin
                    // Next search starts just past the core that was served.
                    state  <= ARB_IDLE;
                    rr_ptr <= (owner == IDX_W'(NUM_CORES - 1)) ? '0 : owner + 1'b1;
                end
            endcase

            if (hold) begin
                o_uram_en      <= i_core_uram_en[owner];
                o_uram_addr    <= i_core_uram_addr[owner*ADDR_W +: ADDR_W];
                o_uram_wr_data <= i_core_uram_wdat[owner*DATA_W +: DATA_W];
                o_uram_wr_en   <= i_core_uram_we[owner] & i_core_uram_en[owner];
            end else begin
                o_uram_en      <= 1'b0;
                o_uram_addr    <= '0;
                o_uram_wr_data <= '0;
                o_uram_wr_en   <= 1'b0;
            end
        end
    end

    a_grant_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(o_core_grant));

endmodule

// File: tb/tb_row_uram_arbiter.sv
// Directed bench for row_uram_arbiter with a cycle-level reference model.
module tb_row_uram_arbiter;

    localparam int N      = 8;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 3;

    localparam int P_IDLE  = 0;
    localparam int P_GRANT = 1;
    localparam int P_LOCK  = 2;
    localparam int P_REL   = 3;

    logic                   clk;
    logic                   reset;
    logic [N-1:0]           req;
    logic [N-1:0]           locked;
    logic [N-1:0]           en_v;
    logic [N-1:0]           we_v;
    logic [ADDR_W-1:0]      c_addr [N];
    logic [DATA_W-1:0]      c_dat  [N];
    logic                   uemp;
    logic [N*ADDR_W-1:0]    addr_bus;
    logic [N*DATA_W-1:0]    dat_bus;

    logic [N-1:0]           o_core_grant;
    logic [N-1:0]           o_uram_emptied;
    logic                   o_uram_en;
    logic [ADDR_W-1:0]      o_uram_addr;
    logic [DATA_W-1:0]      o_uram_wr_data;
    logic                   o_uram_wr_en;
    logic                   o_busy;
    logic [IDX_W-1:0]       o_owner_idx;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign addr_bus[g*ADDR_W +: ADDR_W] = c_addr[g];
        assign dat_bus[g*DATA_W +: DATA_W]  = c_dat[g];
    end

    row_uram_arbiter #(.NUM_CORES(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .i_core_req       (req),
        .i_core_locked    (locked),
        .i_core_uram_en   (en_v),
        .i_core_uram_addr (addr_bus),
        .i_core_uram_wdat (dat_bus),
        .i_core_uram_we   (we_v),
        .i_uram_emptied   (uemp),
        .o_core_grant     (o_core_grant),
        .o_uram_emptied   (o_uram_emptied),
        .o_uram_en        (o_uram_en),
        .o_uram_addr      (o_uram_addr),
        .o_uram_wr_data   (o_uram_wr_data),
        .o_uram_wr_en     (o_uram_wr_en),
        .o_busy           (o_busy),
        .o_owner_idx      (o_owner_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;
    bit armed = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: ownership phase, owner and search start, stepped per edge.
    int                 m_phase = P_IDLE;
    int                 m_owner = 0;
    int                 m_start = 0;
    int                 n_phase, n_owner, n_start, cand;
    bit                 found, held_now, held_nxt;
    logic               e_en, e_we;
    logic [ADDR_W-1:0]  e_addr;
    logic [DATA_W-1:0]  e_dat;
    logic [N-1:0]       e_emp;

    initial begin
        e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_dat = '0; e_emp = '0;
        forever begin
            @(posedge clk);
            n_phase  = m_phase;
            n_owner  = m_owner;
            n_start  = m_start;
            held_now = (m_phase == P_GRANT) || (m_phase == P_LOCK);
            if (reset) begin
                n_phase = P_IDLE; n_owner = 0; n_start = 0;
            end else begin
                case (m_phase)
                    P_IDLE: begin
                        found = 1'b0;
                        for (int k = 0; k < N; k++) begin
                            cand = (m_start + k) % N;
                            if (!found && req[cand]) begin
                                found = 1'b1; n_phase = P_GRANT; n_owner = cand;
                            end
                        end
                    end
                    P_GRANT: begin
                        if (locked[m_owner])   n_phase = P_LOCK;
                        else if (!req[m_owner]) n_phase = P_REL;
                    end
                    P_LOCK: if (!locked[m_owner]) n_phase = P_REL;
                    default: begin
                        n_phase = P_IDLE;
                        n_start = (m_owner + 1) % N;
                    end
                endcase
            end
            held_nxt = (n_phase == P_GRANT) || (n_phase == P_LOCK);
            if (!reset && held_now && held_nxt) begin
                e_en   = en_v[m_owner];
                e_we   = we_v[m_owner] & en_v[m_owner];
                e_addr = c_addr[m_owner];
                e_dat  = c_dat[m_owner];
            end else begin
                e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_dat = '0;
            end
            e_emp   = reset ? '0 : {N{uemp}};
            m_phase = n_phase;
            m_owner = n_owner;
            m_start = n_start;
        end
    end

    logic [N-1:0] e_grant;

    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                e_grant = '0;
                if (m_phase == P_GRANT || m_phase == P_LOCK) e_grant[m_owner] = 1'b1;
                chk("m_grant",   o_core_grant,   e_grant);
                chk("m_busy",    o_busy,         m_phase != P_IDLE);
                chk("m_owner",   o_owner_idx,    m_owner);
                chk("m_uram_en", o_uram_en,      e_en);
                chk("m_addr",    o_uram_addr,    e_addr);
                chk("m_wdata",   o_uram_wr_data, e_dat);
                chk("m_wr_en",   o_uram_wr_en,   e_we);
                chk("m_emptied", o_uram_emptied, e_emp);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req = '0; locked = '0; en_v = '0; we_v = '0; uemp = 1'b0;
        for (int i = 0; i < N; i++) begin
            c_addr[i] = '0;
            c_dat[i]  = '0;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    int           order[$];
    int           exp_order[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    logic [N-1:0] g_now, g_prev;
    int           lock_left, gi;

    initial begin
        clear_inputs();
        reset = 1'b1;
        tick(3);
        armed = 1'b1;
        chk("rst_grant", o_core_grant, 0);
        chk("rst_busy",  o_busy, 0);
        chk("rst_owner", o_owner_idx, 0);
        chk("rst_en",    o_uram_en, 0);
        reset = 1'b0;

        // Single requester with a lock held over cycles 2..10.
        do_reset();
        req[3] = 1'b1;
        tick(1);  chk("t1_grant_c1", o_core_grant, 8'h08);
        chk("t1_busy_c1", o_busy, 1);
        tick(1);  locked[3] = 1'b1;
        tick(8);  chk("t1_grant_c10", o_core_grant, 8'h08);
        tick(1);  chk("t1_grant_c11", o_core_grant, 8'h08);
        locked[3] = 1'b0; req[3] = 1'b0;
        tick(1);  chk("t1_grant_c12", o_core_grant, 8'h00);
        chk("t1_busy_c12", o_busy, 1);
        tick(1);  chk("t1_busy_c13", o_busy, 0);
        chk("t1_owner_c13", o_owner_idx, 3);

        // All cores request; each owner locks for four cycles.
        do_reset();
        req = '1;
        g_prev = '0; lock_left = 0;
        for (int cyc = 0; cyc < 300 && order.size() < 9; cyc++) begin
            tick(1);
            g_now = o_core_grant;
            if (g_now != '0 && g_now != g_prev) begin
                gi = 0;
                for (int i = 0; i < N; i++) if (g_now[i]) gi = i;
                order.push_back(gi);
                locked = '0; locked[gi] = 1'b1;
                lock_left = 4;
            end else if (lock_left > 0) begin
                lock_left--;
                if (lock_left == 0) locked = '0;
            end
            g_prev = g_now;
        end
        chk("t2_order_len", order.size(), 9);
        for (int i = 0; i < order.size() && i < 9; i++) chk("t2_order", order[i], exp_order[i]);

        // Abandoned grant moves the pointer past core 5.
        do_reset();
        req[5] = 1'b1;
        tick(1);  chk("t3_grant5", o_core_grant, 8'h20);
        req[5] = 1'b0;
        tick(1);  chk("t3_release", o_core_grant, 8'h00);
        chk("t3_busy", o_busy, 1);
        req[0] = 1'b1; req[6] = 1'b1;
        tick(2);  chk("t3_grant6", o_core_grant, 8'h40);
        chk("t3_owner6", o_owner_idx, 6);
        req = '0;
        tick(3);

        // Datapath: only the owner reaches the URAM, one cycle later.
        do_reset();
        en_v[4] = 1'b1; we_v[4] = 1'b1; c_addr[4] = 12'h3FF; c_dat[4] = 32'h12345678;
        req[2] = 1'b1; en_v[2] = 1'b1; we_v[2] = 1'b1;
        c_addr[2] = 12'h0A5; c_dat[2] = 32'hDEADBEEF;
        tick(1);  chk("t4_grant2", o_core_grant, 8'h04);
        chk("t4_en_c1", o_uram_en, 0);
        chk("t4_addr_c1", o_uram_addr, 0);
        tick(1);  chk("t4_addr", o_uram_addr, 12'h0A5);
        chk("t4_data", o_uram_wr_data, 32'hDEADBEEF);
        chk("t4_wr_en", o_uram_wr_en, 1);
        chk("t4_en", o_uram_en, 1);
        locked[2] = 1'b1; c_addr[2] = 12'h0A6; we_v[2] = 1'b0;
        tick(1);  chk("t4_addr2", o_uram_addr, 12'h0A6);
        chk("t4_wr_en2", o_uram_wr_en, 0);
        locked[2] = 1'b0; req[2] = 1'b0;
        tick(1);  chk("t4_rel_en", o_uram_en, 0);
        chk("t4_rel_addr", o_uram_addr, 0);
        chk("t4_rel_grant", o_core_grant, 0);

        // Reset while core 7 holds the lock, then emptied broadcast.
        do_reset();
        req[7] = 1'b1; en_v[7] = 1'b1; we_v[7] = 1'b1;
        c_addr[7] = 12'h777; c_dat[7] = 32'h00000007;
        tick(1);  locked[7] = 1'b1;
        tick(1);  req = '1;
        tick(1);  chk("t5_grant7", o_core_grant, 8'h80);
        chk("t5_wr_en", o_uram_wr_en, 1);
        reset = 1'b1;
        tick(1);  chk("t5_rst_grant", o_core_grant, 0);
        chk("t5_rst_en", o_uram_en, 0);
        chk("t5_rst_busy", o_busy, 0);
        reset = 1'b0;
        tick(1);  chk("t5_grant0", o_core_grant, 8'h01);
        locked[0] = 1'b1;
        tick(1);  uemp = 1'b1;
        tick(1);  chk("t6_emp_hi", o_uram_emptied, 8'hFF);
        chk("t6_grant", o_core_grant, 8'h01);
        uemp = 1'b0;
        tick(1);  chk("t6_emp_lo", o_uram_emptied, 8'h00);
        chk("t6_grant2", o_core_grant, 8'h01);
        chk("t6_busy", o_busy, 1);
        clear_inputs();
        tick(4);

        armed = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
